// File: rtl/bitstream_loader.sv
// bitstream_loader: host-side initiator for the fabric's serial configuration
// chain. Serializes a byte stream MSB-first onto prog_clk/prog_en/prog_in,
// collects the bits that fall out of prog_out into readback bytes, and, when
// no load is running, drives the fabric's shared clock and reset on the same
// pins.
module bitstream_loader #(
  parameter int CHAIN_LEN = 102,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done,
  input  logic       run_en,
  input  logic       user_rst,
  output logic       prog_clk,
  output logic       prog_en,
  output logic       prog_in,
  input  logic       prog_out
);

  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BITS_TOTAL = BW'(CHAIN_LEN);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, FINISH} state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_q, div_n;       // prog_clk phase divider
  logic [BW-1:0] bits_q, bits_n;     // bits shifted so far in this load
  logic [BW-1:0] bits_inc;
  logic [2:0]    idx_q, idx_n;       // bit position within the current byte
  logic [7:0]    sh_q, sh_n;         // outgoing byte, current bit at [7]
  logic [7:0]    rbs_q, rbs_n;       // readback assembly register
  logic [2:0]    rbc_q, rbc_n;       // readback bits collected in this byte
  logic [7:0]    rb_sample;
  logic [3:0]    rb_pad;
  logic          prog_clk_n, prog_en_n, prog_in_n, s_ready_n;
  logic          rb_valid_n, busy_n, done_n;
  logic [7:0]    rb_data_n;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic plus next value of every registered output and counter
  always_comb begin
    // NOTE: every signal is given a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_n    = state;
    div_n      = div_q;
    bits_n     = bits_q;
    idx_n      = idx_q;
    sh_n       = sh_q;
    rbs_n      = rbs_q;
    rbc_n      = rbc_q;
    prog_clk_n = prog_clk;
    prog_en_n  = prog_en;
    prog_in_n  = prog_in;
    s_ready_n  = 1'b0;
    rb_data_n  = rb_data;
    rb_valid_n = 1'b0;
    busy_n     = busy;
    done_n     = 1'b0;
    bits_inc   = bits_q + 1'b1;
    rb_sample  = {rbs_q[6:0], prog_out};
    rb_pad     = 4'd8 - {1'b0, rbc_q};

    unique case (state)
      IDLE: begin
        prog_en_n = 1'b0;
        prog_in_n = user_rst;
        busy_n    = 1'b0;
        if (start) begin
          // prog_clk drops immediately, even in the middle of a high phase
          state_n    = FETCH;
          prog_clk_n = 1'b0;
          prog_en_n  = 1'b1;
          prog_in_n  = 1'b0;
          s_ready_n  = 1'b1;
          busy_n     = 1'b1;
          div_n      = '0;
          bits_n     = '0;
          rbc_n      = '0;
        end else if (run_en) begin
          if (div_q == DIV_LAST) begin
            div_n      = '0;
            prog_clk_n = ~prog_clk;
          end else begin
            div_n = div_q + 1'b1;
          end
        end else begin
          prog_clk_n = 1'b0;
          div_n      = '0;
        end
      end

      FETCH: begin
        prog_clk_n = 1'b0;
        s_ready_n  = 1'b1;
        if (s_valid && s_ready) begin
          state_n   = LOW;
          sh_n      = s_data;
          idx_n     = 3'd7;
          div_n     = '0;
          prog_in_n = s_data[7];
          s_ready_n = 1'b0;
        end
      end

      LOW: begin
        if (div_q == DIV_LAST) begin
          // Sample the chain output just before the rising edge shifts it
          div_n      = '0;
          state_n    = HIGH;
          prog_clk_n = 1'b1;
          rbs_n      = rb_sample;
          rbc_n      = rbc_q + 1'b1;
          if (rbc_q == 3'd7) begin
            rb_data_n  = rb_sample;
            rb_valid_n = 1'b1;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end

      HIGH: begin
        if (div_q == DIV_LAST) begin
          div_n      = '0;
          bits_n     = bits_inc;
          prog_clk_n = 1'b0;
          if (bits_inc == BITS_TOTAL) begin
            // Whole chain loaded; flush a partial readback byte left-aligned
            state_n   = FINISH;
            prog_en_n = 1'b0;
            prog_in_n = 1'b0;
            if (rbc_q != 3'd0) begin
              rb_data_n  = rbs_q << rb_pad;
              rb_valid_n = 1'b1;
            end
          end else if (idx_q == 3'd0) begin
            state_n   = FETCH;
            s_ready_n = 1'b1;
          end else begin
            state_n   = LOW;
            idx_n     = idx_q - 1'b1;
            sh_n      = {sh_q[6:0], 1'b0};
            prog_in_n = sh_q[6];
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end

      FINISH: begin
        state_n    = IDLE;
        done_n     = 1'b1;
        busy_n     = 1'b0;
        prog_clk_n = 1'b0;
        prog_en_n  = 1'b0;
        prog_in_n  = user_rst;
        div_n      = '0;
      end

      default: state_n = IDLE;
    endcase
  end

  // Counters, shift registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      bits_q   <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      rbs_q    <= '0;
      rbc_q    <= '0;
      prog_clk <= 1'b0;
      prog_en  <= 1'b0;
      prog_in  <= 1'b0;
      s_ready  <= 1'b0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      div_q    <= div_n;
      bits_q   <= bits_n;
      idx_q    <= idx_n;
      sh_q     <= sh_n;
      rbs_q    <= rbs_n;
      rbc_q    <= rbc_n;
      prog_clk <= prog_clk_n;
      prog_en  <= prog_en_n;
      prog_in  <= prog_in_n;
      s_ready  <= s_ready_n;
      rb_data  <= rb_data_n;
      rb_valid <= rb_valid_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule
